// File: rtl/victim_cache_pkg.sv
// Shared types and helpers for the fully-associative victim cache.
package victim_cache_pkg;

  // Controller states: waiting for an L1 miss, writing back a dirty
  // victim, or fetching the requested line from memory.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_e;

  // Width of an entry index / LRU age; at least one bit.
  function automatic int idx_width(input int n);
    if (n > 2) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/victim_cache_assoc_lru.sv
// True-LRU age tracker and replacement picker for the victim cache.
// Ages form a permutation of 0..N-1; age 0 is MRU, age N-1 is LRU.
module victim_lru
  import victim_cache_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int IDX_W       = idx_width(NUM_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   touch,
  input  logic [IDX_W-1:0]       touch_idx,
  input  logic [NUM_ENTRIES-1:0] valid,
  output logic [IDX_W-1:0]       repl_idx
);

  localparam logic [IDX_W-1:0] MAX_AGE = IDX_W'(NUM_ENTRIES - 1);

  logic [IDX_W-1:0] age_r     [NUM_ENTRIES];
  logic [IDX_W-1:0] age_nxt_s [NUM_ENTRIES];
  logic [IDX_W-1:0] inv_idx_s;
  logic             inv_found_s;
  logic [IDX_W-1:0] lru_idx_s;

  // Age update: touched entry becomes 0, entries younger than it age by one.
  always_comb begin
    age_nxt_s = age_r;
    if (touch) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (IDX_W'(i) == touch_idx) begin
          age_nxt_s[i] = '0;
        end else if (age_r[i] < age_r[touch_idx]) begin
          age_nxt_s[i] = age_r[i] + IDX_W'(1);
        end else begin
          age_nxt_s[i] = age_r[i];
        end
      end
    end else begin
      age_nxt_s = age_r;
    end
  end

  // Age registers; reset order makes entry 0 the initial MRU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        age_r[i] <= IDX_W'(i);
      end
    end else begin
      age_r <= age_nxt_s;
    end
  end

  // Replacement choice: lowest-index invalid entry, otherwise the oldest.
  always_comb begin
    inv_idx_s   = '0;
    inv_found_s = 1'b0;
    lru_idx_s   = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        inv_idx_s   = IDX_W'(i);
        inv_found_s = 1'b1;
      end else begin
        inv_found_s = inv_found_s;
      end
      if (age_r[i] == MAX_AGE) begin
        lru_idx_s = IDX_W'(i);
      end else begin
        lru_idx_s = lru_idx_s;
      end
    end
    if (inv_found_s) begin
      repl_idx = inv_idx_s;
    end else begin
      repl_idx = lru_idx_s;
    end
  end

endmodule

// File: rtl/victim_cache_assoc.sv
// Fully-associative victim cache and swap controller between L1 and memory.
// Hits swap the requested line with L1's victim in a single cycle; misses
// install the victim (writing back a dirty LRU line first) and then pass a
// memory fill straight through to L1.
module victim_cache_assoc
  import victim_cache_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int TAG_W       = 27,
  parameter int LINE_W      = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              l1_req,
  input  logic [TAG_W-1:0]  l1_tag,
  input  logic              l1_evict,
  input  logic [TAG_W-1:0]  l1_evict_tag,
  input  logic [LINE_W-1:0] l1_evict_data,
  input  logic              l1_evict_dirty,
  output logic              l1_resp,
  output logic [LINE_W-1:0] l1_rdata,
  output logic              l1_rdirty,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [TAG_W-1:0]  pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int IDX_W = idx_width(NUM_ENTRIES);

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
  } entry_t;

  // Valid/dirty are reset; tag and data arrays deliberately are not.
  logic [NUM_ENTRIES-1:0] valid_r;
  logic [NUM_ENTRIES-1:0] dirty_r;
  logic [TAG_W-1:0]       tag_r  [NUM_ENTRIES];
  logic [LINE_W-1:0]      data_r [NUM_ENTRIES];
  entry_t                 entry_s [NUM_ENTRIES];

  state_e           state_r;
  state_e           state_nxt_s;
  logic [IDX_W-1:0] vidx_r;
  logic [IDX_W-1:0] vidx_nxt_s;

  logic             hit_s;
  logic [IDX_W-1:0] hit_idx_s;
  logic [IDX_W-1:0] repl_idx_s;

  logic             ins_en_s;
  logic             inv_en_s;
  logic [IDX_W-1:0] wr_idx_s;
  logic             touch_s;

  // Assemble a per-entry view of the storage arrays.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      entry_s[i].valid = valid_r[i];
      entry_s[i].dirty = dirty_r[i];
      entry_s[i].tag   = tag_r[i];
      entry_s[i].data  = data_r[i];
    end
  end

  // Parallel tag lookup; lowest matching index wins (at most one matches).
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (entry_s[i].valid && (entry_s[i].tag == l1_tag)) begin
        hit_s     = 1'b1;
        hit_idx_s = IDX_W'(i);
      end else begin
        hit_s     = hit_s;
      end
    end
  end

  victim_lru #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .IDX_W       (IDX_W)
  ) u_lru (
    .clk       (clk),
    .rst_n     (rst_n),
    .touch     (touch_s),
    .touch_idx (wr_idx_s),
    .valid     (valid_r),
    .repl_idx  (repl_idx_s)
  );

  // Next-state, entry write controls and L1/memory outputs.
  always_comb begin
    state_nxt_s = state_r;
    vidx_nxt_s  = vidx_r;
    ins_en_s    = 1'b0;
    inv_en_s    = 1'b0;
    touch_s     = 1'b0;
    wr_idx_s    = vidx_r;
    l1_resp     = 1'b0;
    l1_rdata    = entry_s[hit_idx_s].data;
    l1_rdirty   = entry_s[hit_idx_s].dirty;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    pmem_addr   = l1_tag;
    pmem_wdata  = entry_s[vidx_r].data;
    case (state_r)
      IDLE: begin
        if (l1_req && hit_s) begin
          // Swap on hit: the evicted line replaces the returned one in place.
          l1_resp  = 1'b1;
          wr_idx_s = hit_idx_s;
          if (l1_evict) begin
            ins_en_s = 1'b1;
            touch_s  = 1'b1;
          end else begin
            inv_en_s = 1'b1;
          end
        end else if (l1_req && l1_evict) begin
          vidx_nxt_s = repl_idx_s;
          wr_idx_s   = repl_idx_s;
          if (entry_s[repl_idx_s].valid && entry_s[repl_idx_s].dirty) begin
            state_nxt_s = WRITEBACK;
          end else begin
            ins_en_s    = 1'b1;
            touch_s     = 1'b1;
            state_nxt_s = FILL;
          end
        end else if (l1_req) begin
          state_nxt_s = FILL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITEBACK: begin
        pmem_write = 1'b1;
        pmem_addr  = entry_s[vidx_r].tag;
        if (pmem_resp) begin
          ins_en_s    = 1'b1;
          touch_s     = 1'b1;
          state_nxt_s = FILL;
        end else begin
          state_nxt_s = WRITEBACK;
        end
      end
      FILL: begin
        pmem_read = 1'b1;
        l1_rdata  = pmem_rdata;
        l1_rdirty = 1'b0;
        if (pmem_resp) begin
          l1_resp     = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = FILL;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Controller state and the victim slot latched on leaving IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      vidx_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      vidx_r  <= vidx_nxt_s;
    end
  end

  // Valid/dirty bookkeeping for installs and hit invalidations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
      dirty_r <= '0;
    end else if (ins_en_s) begin
      valid_r[wr_idx_s] <= 1'b1;
      dirty_r[wr_idx_s] <= l1_evict_dirty;
    end else if (inv_en_s) begin
      valid_r[wr_idx_s] <= 1'b0;
      dirty_r[wr_idx_s] <= 1'b0;
    end else begin
      valid_r <= valid_r;
      dirty_r <= dirty_r;
    end
  end

  // Tag and data capture of the evicted L1 line.
  always_ff @(posedge clk) begin
    if (ins_en_s) begin
      tag_r[wr_idx_s]  <= l1_evict_tag;
      data_r[wr_idx_s] <= l1_evict_data;
    end
  end

endmodule

// File: tb/tb_victim_cache_assoc.sv
// Self-checking bench for victim_cache_assoc: table of L1 transactions with
// expected responses and memory traffic checked through scoreboard queues.
module tb_victim_cache_assoc;

  localparam int N  = 4;
  localparam int TW = 27;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          l1_req = 1'b0;
  logic [TW-1:0] l1_tag = '0;
  logic          l1_evict = 1'b0;
  logic [TW-1:0] l1_evict_tag = '0;
  logic [LW-1:0] l1_evict_data = '0;
  logic          l1_evict_dirty = 1'b0;
  logic          l1_resp;
  logic [LW-1:0] l1_rdata;
  logic          l1_rdirty;
  logic          pmem_read;
  logic          pmem_write;
  logic [TW-1:0] pmem_addr;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  bit mem_hold = 1'b0;
  int mem_cnt = 0;

  victim_cache_assoc #(.NUM_ENTRIES(N), .TAG_W(TW), .LINE_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .l1_req(l1_req), .l1_tag(l1_tag),
    .l1_evict(l1_evict), .l1_evict_tag(l1_evict_tag),
    .l1_evict_data(l1_evict_data), .l1_evict_dirty(l1_evict_dirty),
    .l1_resp(l1_resp), .l1_rdata(l1_rdata), .l1_rdirty(l1_rdirty),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] evd(input logic [TW-1:0] t);
    logic [31:0] w;
    w = 32'hD000_0000 | {5'd0, t};
    return {8{w}};
  endfunction

  function automatic logic [LW-1:0] mem_line(input logic [TW-1:0] t);
    logic [31:0] w;
    w = 32'hAA00_0000 | {5'd0, t};
    return {8{w}};
  endfunction

  typedef struct {
    logic [TW-1:0] tag;
    logic          ev;
    logic [TW-1:0] etag;
    logic          edirty;
    logic          hit;
    logic          wb;
    logic [TW-1:0] wb_tag;
    logic          rdirty;
  } vec_t;

  typedef struct { logic [LW-1:0] data; logic dirty; } resp_t;
  typedef struct { logic [TW-1:0] addr; logic [LW-1:0] data; } wr_t;

  resp_t         exp_resp_q[$];
  wr_t           exp_wr_q[$];
  logic [TW-1:0] exp_rd_q[$];

  vec_t vecs[20];

  resp_t         r_m;
  wr_t           w_m;
  logic [TW-1:0] a_m;

  // Memory model: answers any strobe two cycles after it appears.
  always @(posedge clk) begin
    #1;
    if (pmem_resp) begin
      pmem_resp = 1'b0;
      mem_cnt   = 0;
    end else if ((pmem_read || pmem_write) && !mem_hold) begin
      mem_cnt++;
      if (mem_cnt >= 2) begin
        pmem_resp  = 1'b1;
        pmem_rdata = mem_line(pmem_addr);
      end
    end else begin
      mem_cnt = 0;
    end
  end

  // Output monitor: pops expected items as the DUT produces them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pmem_read && pmem_write) begin
        n_fail++;
        $display("FAIL strobes: read=%b write=%b both high", pmem_read, pmem_write);
      end
      if (l1_resp) begin
        n_tests++;
        if (exp_resp_q.size() == 0) begin
          n_fail++;
          $display("FAIL resp: unexpected l1_resp, rdata=%h", l1_rdata);
        end else begin
          r_m = exp_resp_q.pop_front();
          if (l1_rdata !== r_m.data || l1_rdirty !== r_m.dirty) begin
            n_fail++;
            $display("FAIL resp: got %h/%b want %h/%b", l1_rdata, l1_rdirty, r_m.data, r_m.dirty);
          end
        end
      end
      if (pmem_write && pmem_resp) begin
        n_tests++;
        if (exp_wr_q.size() == 0) begin
          n_fail++;
          $display("FAIL wb: unexpected write addr=%h", pmem_addr);
        end else begin
          w_m = exp_wr_q.pop_front();
          if (pmem_addr !== w_m.addr || pmem_wdata !== w_m.data) begin
            n_fail++;
            $display("FAIL wb: got %h/%h want %h/%h", pmem_addr, pmem_wdata, w_m.addr, w_m.data);
          end
        end
      end
      if (pmem_read && pmem_resp) begin
        n_tests++;
        if (exp_rd_q.size() == 0) begin
          n_fail++;
          $display("FAIL rd: unexpected read addr=%h", pmem_addr);
        end else begin
          a_m = exp_rd_q.pop_front();
          if (pmem_addr !== a_m) begin
            n_fail++;
            $display("FAIL rd: got addr %h want %h", pmem_addr, a_m);
          end
        end
      end
    end
  end

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // Drive one L1 request and wait (bounded) for its response.
  task automatic run_vec(input int idx, input vec_t v);
    resp_t r;
    wr_t   w;
    int    cyc;
    bit    done;
    r.data  = v.hit ? evd(v.tag) : mem_line(v.tag);
    r.dirty = v.hit ? v.rdirty : 1'b0;
    exp_resp_q.push_back(r);
    if (v.wb) begin
      w.addr = v.wb_tag;
      w.data = evd(v.wb_tag);
      exp_wr_q.push_back(w);
    end
    if (!v.hit) exp_rd_q.push_back(v.tag);
    l1_req         = 1'b1;
    l1_tag         = v.tag;
    l1_evict       = v.ev;
    l1_evict_tag   = v.etag;
    l1_evict_data  = evd(v.etag);
    l1_evict_dirty = v.edirty;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      if (l1_resp) done = 1'b1;
      else cyc++;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL timeout: vec %0d no l1_resp in %0d cycles", idx, cyc);
    end
    n_tests++;
    if ((cyc == 0) !== v.hit) begin
      n_fail++;
      $display("FAIL latency: vec %0d cycles=%0d want hit=%b", idx, cyc, v.hit);
    end
    @(posedge clk);
    #1;
    l1_req   = 1'b0;
    l1_evict = 1'b0;
    n_tests++;
    if (exp_wr_q.size() != 0 || exp_rd_q.size() != 0 || exp_resp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending: vec %0d left wr=%0d rd=%0d resp=%0d want 0", idx,
               exp_wr_q.size(), exp_rd_q.size(), exp_resp_q.size());
    end
    exp_wr_q.delete();
    exp_rd_q.delete();
    exp_resp_q.delete();
  endtask

  initial begin
    //            tag     ev    etag    edirty hit   wb    wb_tag  rdirty
    vecs[0]  = '{27'h100, 1'b1, 27'h10, 1'b0, 1'b0, 1'b0, 27'h0,  1'b0};
    vecs[1]  = '{27'h101, 1'b1, 27'h11, 1'b0, 1'b0, 1'b0, 27'h0,  1'b0};
    vecs[2]  = '{27'h102, 1'b1, 27'h12, 1'b1, 1'b0, 1'b0, 27'h0,  1'b0};
    vecs[3]  = '{27'h103, 1'b1, 27'h13, 1'b0, 1'b0, 1'b0, 27'h0,  1'b0};
    vecs[4]  = '{27'h11,  1'b1, 27'h20, 1'b1, 1'b1, 1'b0, 27'h0,  1'b0};
    vecs[5]  = '{27'h10,  1'b1, 27'h22, 1'b0, 1'b1, 1'b0, 27'h0,  1'b0};
    vecs[6]  = '{27'h30,  1'b1, 27'h31, 1'b1, 1'b0, 1'b1, 27'h12, 1'b0};
    vecs[7]  = '{27'h20,  1'b0, 27'h0,  1'b0, 1'b1, 1'b0, 27'h0,  1'b1};
    vecs[8]  = '{27'h40,  1'b1, 27'h41, 1'b0, 1'b0, 1'b0, 27'h0,  1'b0};
    vecs[9]  = '{27'h13,  1'b1, 27'h53, 1'b1, 1'b1, 1'b0, 27'h0,  1'b0};
    vecs[10] = '{27'h31,  1'b1, 27'h52, 1'b1, 1'b1, 1'b0, 27'h0,  1'b1};
    vecs[11] = '{27'h22,  1'b1, 27'h50, 1'b1, 1'b1, 1'b0, 27'h0,  1'b0};
    vecs[12] = '{27'h53,  1'b1, 27'h54, 1'b1, 1'b1, 1'b0, 27'h0,  1'b1};
    vecs[13] = '{27'h41,  1'b1, 27'h51, 1'b1, 1'b1, 1'b0, 27'h0,  1'b0};
    vecs[14] = '{27'h60,  1'b1, 27'h61, 1'b1, 1'b0, 1'b1, 27'h52, 1'b0};
    vecs[15] = '{27'h61,  1'b0, 27'h0,  1'b0, 1'b1, 1'b0, 27'h0,  1'b1};
    vecs[16] = '{27'h50,  1'b0, 27'h0,  1'b0, 1'b1, 1'b0, 27'h0,  1'b1};
    vecs[17] = '{27'h51,  1'b0, 27'h0,  1'b0, 1'b0, 1'b0, 27'h0,  1'b0};
    vecs[18] = '{27'h80,  1'b1, 27'h81, 1'b1, 1'b0, 1'b0, 27'h0,  1'b0};
    vecs[19] = '{27'h81,  1'b0, 27'h0,  1'b0, 1'b1, 1'b0, 27'h0,  1'b1};

    #2 rst_n = 1'b0;
    #1;
    check1("rst_resp", l1_resp, 1'b0);
    check1("rst_pread", pmem_read, 1'b0);
    check1("rst_pwrite", pmem_write, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

    // Reset while a fill is outstanding: strobe must drop asynchronously.
    mem_hold = 1'b1;
    l1_req   = 1'b1;
    l1_tag   = 27'h70;
    l1_evict = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check1("fill_strobe", pmem_read, 1'b1);
    check1("fill_addr", pmem_addr == 27'h70, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check1("midfill_pread", pmem_read, 1'b0);
    check1("midfill_pwrite", pmem_write, 1'b0);
    check1("midfill_resp", l1_resp, 1'b0);
    l1_req   = 1'b0;
    mem_hold = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 17; i < 20; i++) run_vec(i, vecs[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
